// File: rtl/operand_mult_pkg.sv
// Shared constants for the operand/multiply responder: command codes, FSM states
// and default sizing.
package operand_mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int ADR_W     = 3;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD_A = 3'b001;
  localparam logic [2:0] OP_LOAD_B = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_WRITE  = 3'b100;
  localparam logic [2:0] OP_READ   = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one partial product per cycle, WIDTH cycles per product.
// Two's complement operands when MUL_SIGNED_EN is defined, unsigned otherwise.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q, done_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_start;
  logic [2*WIDTH-1:0] acc_d, prod_d;

`ifdef MUL_SIGNED_EN
  // Multiply magnitudes; the most negative value's magnitude still fits unsigned.
  assign a_mag     = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag     = b_i[WIDTH-1] ? -b_i : b_i;
  assign neg_start = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`else
  assign a_mag     = a_i;
  assign b_mag     = b_i;
  assign neg_start = 1'b0;
`endif

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_d = neg_q ? -acc_d : acc_d;
  assign last_o = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        busy_q   <= 1'b1;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
        mplier_q <= b_mag;
        neg_q    <= neg_start;
      end else if (busy_q) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (last_o) begin
          busy_q <= 1'b0;
          prod_q <= prod_d;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/operand_mult_responder.sv
// Command responder: register file, operand latches, result RAM and the IDLE/MULT
// handshake FSM. Signed multiply is selected with the MUL_SIGNED_EN macro.
module operand_mult_responder
  import operand_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rf_we,
  input  logic [ADR_W-1:0]   rf_wadr,
  input  logic [WIDTH-1:0]   rf_wdata,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [ADR_W-1:0]   cmd_adr,
  output logic               cmd_ready,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product,
  output logic               mul_done,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               err,
  output logic               dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is low only while a multiply runs, and commands offered then are dropped.
  state_t             state_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic [2*WIDTH-1:0] rd_data_q;
  logic               rd_valid_q, err_q;
  logic [WIDTH-1:0]   rf_q  [DEPTH];
  logic [2*WIDTH-1:0] ram_q [DEPTH];

  logic accept, mult_start, mult_last;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign mult_start = accept && (cmd_op == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mult_start),
    .a_i       (op_a_q),
    .b_i       (op_b_q),
    .last_o    (mult_last),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i]  <= '0;
        ram_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
      if (rf_we) rf_q[rf_wadr] <= rf_wdata;

      case (state_q)
        ST_IDLE: if (mult_start) state_q <= ST_MULT;
        ST_MULT: if (mult_last)  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Loads read rf_q before this edge's host write lands, so they see old data.
      if (accept) begin
        case (cmd_op)
          OP_NOP:    ;
          OP_LOAD_A: op_a_q <= rf_q[cmd_adr];
          OP_LOAD_B: op_b_q <= rf_q[cmd_adr];
          OP_MUL:    ;
          OP_WRITE:  ram_q[cmd_adr] <= product;
          OP_READ: begin
            rd_data_q  <= ram_q[cmd_adr];
            rd_valid_q <= 1'b1;
          end
          default:   err_q <= 1'b1;
        endcase
      end
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign dbg_state = (state_q == ST_MULT);

endmodule

// File: tb/tb_operand_mult_responder.sv
// Bench for operand_mult_responder: vector table, directed corner sequences and a
// random command stream checked against a command-level reference model.
module tb_operand_mult_responder;

  localparam int WIDTH = 8;
  localparam logic [2:0] C_NOP = 3'd0, C_LDA = 3'd1, C_LDB = 3'd2, C_MUL = 3'd3,
                         C_WR  = 3'd4, C_RD  = 3'd5, C_ILL = 3'd6;

  logic        clk, reset;
  logic        rf_we;
  logic [2:0]  rf_wadr;
  logic [7:0]  rf_wdata;
  logic        cmd_valid;
  logic [2:0]  cmd_op, cmd_adr;
  logic        cmd_ready;
  logic [7:0]  op_a, op_b;
  logic [15:0] product, rd_data;
  logic        mul_done, rd_valid, err, dbg_state;

  operand_mult_responder dut (
    .clk(clk), .reset(reset), .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_wdata(rf_wdata),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_adr(cmd_adr), .cmd_ready(cmd_ready),
    .op_a(op_a), .op_b(op_b), .product(product), .mul_done(mul_done),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int          checks = 0, errors = 0;
  logic [7:0]  m_rf  [8];
  logic [15:0] m_ram [8];
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod;
  logic        m_err;
  bit          noise_load_a = 1'b0;

  typedef struct {
    logic [2:0]  ra, rb;
    logic [7:0]  a, b;
    logic [15:0] exp_u, exp_s;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
`ifdef MUL_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
`else
    p = int'(a) * int'(b);
`endif
    return p[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_rf[i]  = '0;
      m_ram[i] = '0;
    end
    m_a = '0; m_b = '0; m_prod = '0; m_err = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Issues one command (plus an optional host rf write in the same cycle) and,
  // for MUL, runs the busy window while offering commands that must be dropped.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] adr,
                        input logic we, input logic [2:0] wadr, input logic [7:0] wdata);
    logic [15:0] exp_rd;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr;
    rf_we = we; rf_wadr = wadr; rf_wdata = wdata;
    exp_rd = m_ram[adr];
    case (op)
      C_LDA:   m_a = m_rf[adr];
      C_LDB:   m_b = m_rf[adr];
      C_MUL:   m_prod = ref_mul(m_a, m_b);
      C_WR:    m_ram[adr] = m_prod;
      3'd6, 3'd7: m_err = 1'b1;
      default: ;
    endcase
    if (we) m_rf[wadr] = wdata;
    step();
    cmd_valid = 1'b0; rf_we = 1'b0;
    if (op == C_MUL) begin
      for (int i = 0; i < WIDTH; i++) begin
        check("busy_ready_low", cmd_ready, 0);
        check("busy_no_done", mul_done, 0);
        cmd_valid = 1'b1;
        cmd_op    = noise_load_a ? C_LDA : 3'($urandom_range(0, 7));
        cmd_adr   = 3'($urandom_range(0, 7));
        rf_we     = 1'($urandom_range(0, 1));
        rf_wadr   = 3'($urandom_range(0, 7));
        rf_wdata  = 8'($urandom_range(0, 255));
        if (rf_we) m_rf[rf_wadr] = rf_wdata;
        step();
      end
      cmd_valid = 1'b0; rf_we = 1'b0;
    end
    check("mul_done", mul_done, (op == C_MUL));
    check("product", product, m_prod);
    check("rd_valid", rd_valid, (op == C_RD));
    if (op == C_RD) check("rd_data", rd_data, exp_rd);
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("err", err, m_err);
    check("ready_after_cmd", cmd_ready, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] exp_p;
    logic        saw_done;

    vecs[0] = '{ra: 3'd2, rb: 3'd5, a: 8'd7,   b: 8'd9,   exp_u: 16'd63,   exp_s: 16'd63};
    vecs[1] = '{ra: 3'd0, rb: 3'd1, a: 8'hFF,  b: 8'hFF,  exp_u: 16'hFE01, exp_s: 16'h0001};
    vecs[2] = '{ra: 3'd3, rb: 3'd4, a: 8'hFD,  b: 8'h05,  exp_u: 16'h04F1, exp_s: 16'hFFF1};
    vecs[3] = '{ra: 3'd6, rb: 3'd7, a: 8'h80,  b: 8'h80,  exp_u: 16'h4000, exp_s: 16'h4000};
    vecs[4] = '{ra: 3'd1, rb: 3'd1, a: 8'h00,  b: 8'h00,  exp_u: 16'h0000, exp_s: 16'h0000};
    vecs[5] = '{ra: 3'd4, rb: 3'd2, a: 8'h01,  b: 8'hFF,  exp_u: 16'h00FF, exp_s: 16'hFFFF};
    vecs[6] = '{ra: 3'd5, rb: 3'd0, a: 8'h80,  b: 8'h01,  exp_u: 16'h0080, exp_s: 16'hFF80};
    vecs[7] = '{ra: 3'd7, rb: 3'd6, a: 8'h7F,  b: 8'h80,  exp_u: 16'h3F80, exp_s: 16'hC080};

    reset = 1'b1; rf_we = 1'b0; rf_wadr = '0; rf_wdata = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // reset values
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_product", product, 0);
    check("rst_mul_done", mul_done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_state", dbg_state, 0);

    // table-driven multiplies
    for (int v = 0; v < 8; v++) begin
      do_cmd(C_NOP, 3'd0, 1'b1, vecs[v].ra, vecs[v].a);
      do_cmd(C_NOP, 3'd0, 1'b1, vecs[v].rb, vecs[v].b);
      do_cmd(C_LDA, vecs[v].ra, 1'b0, 3'd0, 8'd0);
      do_cmd(C_LDB, vecs[v].rb, 1'b0, 3'd0, 8'd0);
      do_cmd(C_MUL, 3'd0, 1'b0, 3'd0, 8'd0);
`ifdef MUL_SIGNED_EN
      exp_p = vecs[v].exp_s;
`else
      exp_p = vecs[v].exp_u;
`endif
      check("table_product", product, exp_p);
      if (v == 0) begin
        do_cmd(C_WR, 3'd3, 1'b0, 3'd0, 8'd0);
        do_cmd(C_RD, 3'd3, 1'b0, 3'd0, 8'd0);
        check("write_read_63", rd_data, 16'd63);
      end
    end

    // host write colliding with LOAD_A at the same address returns the old data
    do_cmd(C_NOP, 3'd0, 1'b1, 3'd4, 8'h11);
    do_cmd(C_LDA, 3'd4, 1'b1, 3'd4, 8'h22);
    check("collide_old", op_a, 8'h11);
    do_cmd(C_LDA, 3'd4, 1'b0, 3'd0, 8'd0);
    check("collide_new", op_a, 8'h22);

    // LOAD_A offered throughout a multiply must be dropped
    do_cmd(C_NOP, 3'd0, 1'b1, 3'd6, 8'd12);
    do_cmd(C_LDB, 3'd6, 1'b0, 3'd0, 8'd0);
    noise_load_a = 1'b1;
    do_cmd(C_MUL, 3'd0, 1'b0, 3'd0, 8'd0);
    noise_load_a = 1'b0;
    check("ignored_lda_op_a", op_a, 8'h22);
    check("ignored_lda_prod", product, ref_mul(8'h22, 8'd12));

    // illegal op sets a sticky error
    do_cmd(C_ILL, 3'd0, 1'b0, 3'd0, 8'd0);
    check("err_set", err, 1);
    do_cmd(C_NOP, 3'd0, 1'b0, 3'd0, 8'd0);
    do_cmd(C_RD, 3'd3, 1'b0, 3'd0, 8'd0);
    do_cmd(C_LDA, 3'd2, 1'b0, 3'd0, 8'd0);
    check("err_sticky", err, 1);

    // random command stream
    for (int n = 0; n < 150; n++)
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));

    // reset four cycles into a multiply
    do_cmd(C_NOP, 3'd0, 1'b1, 3'd1, 8'd200);
    do_cmd(C_NOP, 3'd0, 1'b1, 3'd2, 8'd3);
    do_cmd(C_LDA, 3'd1, 1'b0, 3'd0, 8'd0);
    do_cmd(C_LDB, 3'd2, 1'b0, 3'd0, 8'd0);
    do_cmd(C_MUL, 3'd0, 1'b0, 3'd0, 8'd0);
    do_cmd(C_WR, 3'd6, 1'b0, 3'd0, 8'd0);
    cmd_valid = 1'b1; cmd_op = C_MUL;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    check("pre_reset_busy", cmd_ready, 0);
    reset = 1'b1;
    #2;
    check("abort_product", product, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", mul_done, 0);
    check("abort_err", err, 0);
    step();
    reset = 1'b0;
    model_clear();
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw_done |= mul_done;
      step();
    end
    check("no_done_after_abort", saw_done, 0);
    check("abort_product_hold", product, 0);
    for (int a = 0; a < 8; a++) do_cmd(C_RD, 3'(a), 1'b0, 3'd0, 8'd0);

    for (int n = 0; n < 60; n++)
      do_cmd(3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
